mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide RAM/IO port between the instruction fetcher (32-bit reads) and the load/store buffer (1/2/4-byte reads and writes).
- Serialises each request into byte transfers and assembles little-endian results.
- Aborts speculative reads on branch mispredict.
- Sits between the fetcher/LSB and the top-level RAM/IO bus.

Parameters:
ADDR_W, 32, address width of all address ports
IO_MASK, 32'h00030000, an address with (addr & IO_MASK)==IO_MASK is IO space

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low freezes all state
jump_wrong  in  1  mispredict flush
mem_din  in  8  RAM read data for the address driven in the previous cycle
mem_dout  out  8  RAM write data
mem_a  out  ADDR_W  RAM address
mem_wr  out  1  1=write, 0=read
io_buffer_full  in  1  IO write buffer full
if_req  in  1  fetch request, level
if_addr  in  ADDR_W  fetch address
if_done  out  1  fetch complete pulse
if_data  out  32  fetched instruction
lsb_read_signal  in  1  load request, level
lsb_write_signal  in  1  store request, level
requiring_length  in  3  byte count: 1, 2 or 4
to_mem_addr  in  ADDR_W  load/store address
to_mem_data  in  32  store data; low bytes used
mem_load_success  out  1  load complete pulse
mem_store_success  out  1  store complete pulse
from_mem_data  out  32  load data, zero-extended (requester sign-extends)

Behaviour:
- Reset (async, rst=1): state=IDLE, mem_a=0, mem_dout=0, mem_wr=0, all done/success pulses=0, if_data=0, from_mem_data=0, byte counter=0, rr_lsb_last=0.
- rdy=0: no state change and no new acceptance. mem_wr is forced to 0 combinationally, so no write is repeated during a stall.
- States: IDLE, READ, WRITE, DONE.
- Arbitration in IDLE, sampled at the posedge:
  - Among LSB requests, write beats read.
  - Between the LSB class and fetch, round-robin: if both are pending, the class not granted last wins. rr_lsb_last updates on each grant.
  - Fetch length is fixed at 4.
- Acceptance edge E0:
  - Latch source, base address, length n and store data.
  - Drive mem_a=addr. For a write, also drive mem_wr=1 and mem_dout=byte0.
  - Go to READ or WRITE.
- READ:
  - At edges E1..E(n-1), drive mem_a=addr+k.
  - At edge E(k+1), capture mem_din into byte k.
  - At edge En, capture the last byte, pulse the matching done/success with assembled data, and go to DONE.
  - n-byte read latency: pulse visible in the cycle after edge En.
- WRITE:
  - At edges E1..E(n-1), drive mem_a=addr+k, mem_dout=byte k, mem_wr=1.
  - At edge En, set mem_wr=0, pulse mem_store_success, and go to DONE.
  - IO address with io_buffer_full=1: before driving each byte, hold with mem_wr=0 and keep the counter until full=0.
- DONE:
  - Lasts exactly one cycle and deasserts all pulses.
  - Requests are ignored here so a requester dropping its level on the success edge is not re-accepted.
  - Then go to IDLE.
- Pulses are exactly one cycle wide. Data outputs hold until the next completion.
- jump_wrong=1 at an edge:
  - In READ (fetch or load): abort to IDLE, mem_a unchanged, no pulse.
  - In IDLE: requests are not accepted that edge.
  - In WRITE: not affected; stores are committed and must finish.
  - Flush during DONE: go to IDLE normally.
- Address increment wraps modulo 2^ADDR_W.
- A length other than 1, 2 or 4 is treated as 4.
- Reset asserted mid-transaction: immediate return to reset values; a partial store is not completed.

Decomposition:
- Shared define package: length encodings REQ8/REQ16/REQ32 = 1/2/4, state encodings, IO_MASK, TRUE/FALSE.
- One natural sub-module, mem_byte_sequencer. It holds the byte counter, address increment and byte assemble/select, and emits last_byte.
- The arbiter/FSM stays in mem_ctrl.

Test Plan:
- Fetch alone, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00:
  - mem_a = 0x100, 0x101, 0x102, 0x103 on consecutive cycles.
  - if_done pulses 4 edges after acceptance with if_data=0x00000513.
- SB to 0x200 with data 0xAABBCCDD: one cycle with mem_wr=1, mem_a=0x200, mem_dout=0xDD, then mem_store_success one cycle. A 4-byte SW writes DD,CC,BB,AA to 0x200..0x203.
- Fetch, load and store asserted together from IDLE:
  - Grant order is store, fetch, load.
  - Each completion is followed by one DONE cycle; no request is accepted twice.
- LH from 0x300 (bytes 0x34, 0x12): mem_load_success pulse with from_mem_data=0x00001234. Assert jump_wrong after byte 0 on a second load: no pulse, state IDLE next cycle.
- SB to 0x30000 with io_buffer_full=1 for 5 cycles: mem_wr stays 0 for those cycles; the write then issues once and success pulses.
- Assert rdy=0 mid-write, and separately assert rst mid-read:
  - With rdy=0, mem_wr=0 and counter/address are frozen, and the write resumes when rdy returns.
  - With rst, outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: request lengths,
// FSM states, IO space mask and length normalisation.
package mem_ctrl_pkg;
  localparam logic [2:0]  REQ8        = 3'd1;
  localparam logic [2:0]  REQ16       = 3'd2;
  localparam logic [2:0]  REQ32       = 3'd4;
  localparam logic [31:0] IO_MASK_DEF = 32'h0003_0000;
  localparam logic        TRUE        = 1'b1;
  localparam logic        FALSE       = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  // Index of the final byte; any unsupported length behaves as a word.
  function automatic logic [1:0] last_idx(input logic [2:0] len);
    case (len)
      REQ8:    return 2'd0;
      REQ16:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction
endpackage

// File: rtl/mem_byte_sequencer.sv
// Byte counter, address increment, store-byte select and little-endian
// assembly of read bytes for one serialised request.
module mem_byte_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_capture,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [2:0]        i_len,
  input  logic [31:0]       i_wdata,
  input  logic [7:0]        i_din,
  output logic [ADDR_W-1:0] o_addr_nxt,
  output logic [7:0]        o_byte_nxt,
  output logic              o_last_byte,
  output logic [31:0]       o_rdata_nxt
);
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_asm;
  logic [1:0]        w_cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
    end else if (i_start) begin
      r_base     <= i_base;
      r_cnt      <= '0;
      r_last_idx <= last_idx(i_len);
      r_wdata    <= i_wdata;
      r_asm      <= '0;
    end else begin
      if (i_capture) r_asm <= o_rdata_nxt;
      if (i_step)    r_cnt <= w_cnt_inc;
    end
  end

  assign w_cnt_inc   = r_cnt + 2'd1;
  assign o_last_byte = (r_cnt == r_last_idx);
  // Wraps naturally at the address width.
  assign o_addr_nxt  = r_base + ADDR_W'(r_cnt) + ADDR_W'(1);
  assign o_byte_nxt  = r_wdata[{w_cnt_inc, 3'b000} +: 8];

  // Assembled word including the byte arriving this cycle.
  always_comb begin
    o_rdata_nxt = r_asm;
    o_rdata_nxt[{r_cnt, 3'b000} +: 8] = i_din;
  end
endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM/IO port between instruction fetch and the
// load/store buffer, serialising each request into byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_MASK = ADDR_W'(IO_MASK_DEF)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_read_signal,
  input  logic              lsb_write_signal,
  input  logic [2:0]        requiring_length,
  input  logic [ADDR_W-1:0] to_mem_addr,
  input  logic [31:0]       to_mem_data,
  output logic              mem_load_success,
  output logic              mem_store_success,
  output logic [31:0]       from_mem_data
);
  state_t            r_state, w_state_nxt;
  logic              r_src_if, r_rr_lsb_last;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_if_done, r_load_ok, r_store_ok;
  logic [31:0]       r_if_data, r_ld_data;

  logic              w_lsb_req, w_accept, w_acc_if, w_acc_wr;
  logic              w_start, w_step, w_capture, w_last;
  logic [ADDR_W-1:0] w_acc_addr, w_addr_nxt;
  logic [2:0]        w_acc_len;
  logic [7:0]        w_byte_nxt;
  logic [31:0]       w_rdata_nxt;

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return (a & IO_MASK) == IO_MASK;
  endfunction

  assign w_lsb_req  = lsb_read_signal | lsb_write_signal;
  assign w_acc_addr = w_acc_if ? if_addr : to_mem_addr;
  assign w_acc_len  = w_acc_if ? REQ32 : requiring_length;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = FALSE;
    w_acc_if    = FALSE;
    w_acc_wr    = FALSE;
    case (r_state)
      S_IDLE: if (!jump_wrong && (if_req || w_lsb_req)) begin
        w_accept    = TRUE;
        w_acc_if    = if_req && (!w_lsb_req || r_rr_lsb_last);
        w_acc_wr    = !w_acc_if && lsb_write_signal;
        w_state_nxt = w_acc_wr ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (jump_wrong)  w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_WRITE: if (r_mem_wr && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= S_IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  assign w_start   = rdy && w_accept;
  assign w_capture = rdy && (r_state == S_READ) && !jump_wrong;
  assign w_step    = rdy && !w_last &&
                     (((r_state == S_READ) && !jump_wrong) ||
                      ((r_state == S_WRITE) && r_mem_wr));

  mem_byte_sequencer #(.ADDR_W(ADDR_W)) u_seq (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_step      (w_step),
    .i_capture   (w_capture),
    .i_base      (w_acc_addr),
    .i_len       (w_acc_len),
    .i_wdata     (to_mem_data),
    .i_din       (mem_din),
    .o_addr_nxt  (w_addr_nxt),
    .o_byte_nxt  (w_byte_nxt),
    .o_last_byte (w_last),
    .o_rdata_nxt (w_rdata_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_if      <= 1'b0;
      r_rr_lsb_last <= 1'b0;
      r_mem_a       <= '0;
      r_mem_dout    <= '0;
      r_mem_wr      <= 1'b0;
      r_if_done     <= 1'b0;
      r_load_ok     <= 1'b0;
      r_store_ok    <= 1'b0;
      r_if_data     <= '0;
      r_ld_data     <= '0;
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_load_ok  <= 1'b0;
      r_store_ok <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_src_if      <= w_acc_if;
          r_rr_lsb_last <= !w_acc_if;
          r_mem_a       <= w_acc_addr;
          if (w_acc_wr) begin
            r_mem_dout <= to_mem_data[7:0];
            r_mem_wr   <= !(is_io(to_mem_addr) && io_buffer_full);
          end
        end
        S_READ: if (!jump_wrong) begin
          if (w_last) begin
            if (r_src_if) begin
              r_if_done <= 1'b1;
              r_if_data <= w_rdata_nxt;
            end else begin
              r_load_ok <= 1'b1;
              r_ld_data <= w_rdata_nxt;
            end
          end else begin
            r_mem_a <= w_addr_nxt;
          end
        end
        // r_mem_wr low in WRITE means the current byte is parked on a full IO buffer.
        S_WRITE: begin
          if (r_mem_wr) begin
            if (w_last) begin
              r_mem_wr   <= 1'b0;
              r_store_ok <= 1'b1;
            end else begin
              r_mem_a    <= w_addr_nxt;
              r_mem_dout <= w_byte_nxt;
              r_mem_wr   <= !(is_io(w_addr_nxt) && io_buffer_full);
            end
          end else if (!(is_io(r_mem_a) && io_buffer_full)) begin
            r_mem_wr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_a             = r_mem_a;
  assign mem_dout          = r_mem_dout;
  assign mem_wr            = r_mem_wr & rdy;
  assign if_done           = r_if_done;
  assign if_data           = r_if_data;
  assign mem_load_success  = r_load_ok;
  assign mem_store_success = r_store_ok;
  assign from_mem_data     = r_ld_data;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed scoreboard bench for mem_ctrl: completion kinds and read data are
// queued at stimulus time and popped when the matching pulse appears.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, io_buffer_full;
  logic        if_req, lsb_read_signal, lsb_write_signal;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, to_mem_addr;
  logic        mem_wr, if_done, mem_load_success, mem_store_success;
  logic [31:0] if_data, to_mem_data, from_mem_data;
  logic [2:0]  requiring_length;

  logic [7:0]  ram [0:262143];
  int          total = 0, bad = 0, nwr = 0, npulse = 0, mkind, w0;
  int          q_kind[$];
  logic [31:0] q_data[$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
    .requiring_length(requiring_length), .to_mem_addr(to_mem_addr),
    .to_mem_data(to_mem_data), .mem_load_success(mem_load_success),
    .mem_store_success(mem_store_success), .from_mem_data(from_mem_data)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[17:0]];
  always @(posedge clk) if (mem_wr) begin
    ram[mem_a[17:0]] <= mem_dout;
    nwr <= nwr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every completion pulse must match the next queued entry.
  always @(negedge clk) begin
    if (if_done || mem_load_success || mem_store_success) begin
      npulse++;
      mkind = if_done ? 1 : (mem_load_success ? 2 : 3);
      if (q_kind.size() == 0) check("unexpected_pulse", mkind, 0);
      else begin
        check("kind", mkind, q_kind.pop_front());
        if (mkind != 3) begin
          if (q_data.size() == 0) check("rdata_unqueued", mkind, 0);
          else check("rdata", (mkind == 1) ? if_data : from_mem_data, q_data.pop_front());
        end
      end
    end
  end

  // Wait for any completion, then drop every request level.
  task automatic wait_pulse(input string tag, input int budget);
    logic seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = if_done | mem_load_success | mem_store_success;
    end
    check(tag, seen, 1'b1);
    if_req = 0; lsb_read_signal = 0; lsb_write_signal = 0;
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] d);
    to_mem_addr = a; requiring_length = len; to_mem_data = d;
    if (wr) lsb_write_signal = 1; else lsb_read_signal = 1;
  endtask

  initial begin
    rst = 1; rdy = 1; jump_wrong = 0; io_buffer_full = 0;
    if_req = 0; if_addr = 0; lsb_read_signal = 0; lsb_write_signal = 0;
    requiring_length = 0; to_mem_addr = 0; to_mem_data = 0;
    for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
    ram[18'h100] <= 8'h13; ram[18'h101] <= 8'h05;
    ram[18'h300] <= 8'h34; ram[18'h301] <= 8'h12;
    ram[18'h400] <= 8'h78; ram[18'h401] <= 8'h56; ram[18'h402] <= 8'h34; ram[18'h403] <= 8'h12;
    repeat (2) @(negedge clk);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_pulses", {if_done, mem_load_success, mem_store_success}, 0);
    check("rst_if_data", if_data, 0);
    check("rst_ld_data", from_mem_data, 0);
    rst = 0;
    @(negedge clk);

    // Fetch alone from 0x100
    if_addr = 32'h100; if_req = 1;
    q_kind.push_back(1); q_data.push_back(32'h0000_0513);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fetch_addr", mem_a, 32'h100 + k);
    end
    @(negedge clk);
    check("fetch_done_lat", if_done, 1);
    if_req = 0;
    @(negedge clk);
    check("fetch_done_width", if_done, 0);
    @(negedge clk);

    // Fetch, load and store together: store, fetch, load
    if_addr = 32'h400; if_req = 1;
    lsb_req(1'b0, 32'h600, REQ16, 32'h0000_BEEF);
    lsb_write_signal = 1;
    q_kind.push_back(3);
    q_kind.push_back(1); q_data.push_back(32'h1234_5678);
    q_kind.push_back(2); q_data.push_back(32'h0000_BEEF);
    npulse = 0;
    for (int c = 0; c < 60 && (if_req || lsb_read_signal || lsb_write_signal); c++) begin
      @(negedge clk);
      if (if_done) if_req = 0;
      if (mem_load_success) lsb_read_signal = 0;
      if (mem_store_success) lsb_write_signal = 0;
    end
    repeat (6) @(negedge clk);
    check("multi_pulses", npulse, 3);
    check("multi_ram", {ram[18'h601], ram[18'h600]}, 16'hBEEF);

    // SB then SW to 0x200
    lsb_req(1'b1, 32'h200, REQ8, 32'hAABB_CCDD);
    q_kind.push_back(3);
    @(negedge clk);
    check("sb_bus", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h200, 8'hDD});
    @(negedge clk);
    check("sb_success", {mem_store_success, mem_wr}, 2'b10);
    lsb_write_signal = 0;
    repeat (2) @(negedge clk);
    check("sb_ram", {ram[18'h201], ram[18'h200]}, 16'h00DD);
    lsb_req(1'b1, 32'h200, REQ32, 32'hAABB_CCDD);
    q_kind.push_back(3);
    wait_pulse("sw_pulse", 20);
    repeat (2) @(negedge clk);
    check("sw_ram", {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]}, 32'hAABB_CCDD);

    // LH from 0x300, then a load aborted by jump_wrong
    lsb_req(1'b0, 32'h300, REQ16, 32'h0);
    q_kind.push_back(2); q_data.push_back(32'h0000_1234);
    wait_pulse("lh_pulse", 20);
    repeat (2) @(negedge clk);
    lsb_req(1'b0, 32'h300, REQ16, 32'h0);
    repeat (2) @(negedge clk);
    jump_wrong = 1; lsb_read_signal = 0;
    @(negedge clk);
    check("jw_state", 32'(dut.r_state), 32'(S_IDLE));
    check("jw_addr", mem_a, 32'h301);
    check("jw_nopulse", mem_load_success, 0);
    check("jw_hold", from_mem_data, 32'h0000_1234);
    jump_wrong = 0;
    repeat (4) @(negedge clk);

    // IO store held off by a full buffer
    io_buffer_full = 1;
    w0 = nwr;
    lsb_req(1'b1, 32'h3_0000, REQ8, 32'h0000_005A);
    q_kind.push_back(3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("io_hold", mem_wr, 0);
    end
    io_buffer_full = 0;
    @(negedge clk);
    check("io_bus", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h3_0000, 8'h5A});
    wait_pulse("io_pulse", 10);
    check("io_once", nwr - w0, 1);
    repeat (2) @(negedge clk);

    // rdy stall in the middle of a word store
    w0 = nwr;
    lsb_req(1'b1, 32'h700, REQ32, 32'h0102_0304);
    q_kind.push_back(3);
    @(negedge clk);
    check("stall_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h700, 8'h04});
    @(negedge clk);
    check("stall_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h701, 8'h03});
    rdy = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_frozen", {mem_wr, mem_a, mem_dout}, {1'b0, 32'h701, 8'h03});
    end
    rdy = 1;
    @(negedge clk);
    check("stall_resume", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h702, 8'h02});
    wait_pulse("stall_pulse", 10);
    check("stall_nwr", nwr - w0, 4);
    repeat (2) @(negedge clk);
    check("stall_ram", {ram[18'h703], ram[18'h702], ram[18'h701], ram[18'h700]}, 32'h0102_0304);

    // Asynchronous reset during a fetch
    if_addr = 32'h400; if_req = 1;
    repeat (2) @(negedge clk);
    check("rst_mid_addr_pre", mem_a, 32'h401);
    #2 rst = 1; if_req = 0;
    #1;
    check("rst_mid_bus", {mem_wr, mem_a, mem_dout}, 41'h0);
    check("rst_mid_data", {if_data, from_mem_data}, 64'h0);
    check("rst_mid_state", 32'(dut.r_state), 32'(S_IDLE));
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    check("sb_drained", q_kind.size(), 0);
    check("sb_data_drained", q_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
